// File: rtl/sram_rdata_ctrl.sv
// sram_rdata_ctrl: read path of the AXI4 SRAM slave.
// Takes the per-beat address stream from the burst address generator, issues one
// SRAM read per accepted beat, captures the data one cycle later and queues it in a
// small circular buffer that drives the AXI4 R channel in order.
// Ports:
//   aclk_i, areset_i             clock, synchronous active-high reset
//   addr_i/addr_last_i/id_i      beat byte address, last-beat flag, burst ID
//   addr_valid_i/addr_ready_o    beat handshake (ready is credit based, registered only)
//   sram_cs_o/sram_addr_o        SRAM read strobe and word address
//   sram_rdata_i                 SRAM read data, valid one cycle after sram_cs_o
//   rid_o/rdata_o/rresp_o/rlast_o/rvalid_o/rready_i   AXI4 R channel
module sram_rdata_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned SRAM_AW    = 10,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                  aclk_i,
    input  logic                  areset_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  addr_last_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic                  addr_valid_i,
    output logic                  addr_ready_o,
    output logic                  sram_cs_o,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i
);

    localparam int unsigned OFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned HI  = SRAM_AW + OFT;
    localparam int unsigned PW  = $clog2(BUF_DEPTH);
    localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } entry_t;

    logic                up_q;       // low for the reset cycle, gates addr_ready_o
    logic                infl_q;     // a read is waiting for sram_rdata_i this cycle
    logic [ID_WIDTH-1:0] infl_id_q;
    logic                infl_last_q;
    logic                infl_err_q;
    entry_t              mem_q [BUF_DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       occ_q;

    logic                oor;
    logic                hs;
    logic                push;
    logic                pop;
    logic [CW:0]         used;
    entry_t              push_entry;
    entry_t              head;

    // Out-of-range: any address bit above the SRAM word address field is set.
    generate
        if (ADDR_WIDTH > HI) begin : g_hi
            assign oor = |addr_i[ADDR_WIDTH-1:HI];
        end else begin : g_nohi
            assign oor = 1'b0;
        end
        if (OFT > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^addr_i[OFT-1:0];
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit: buffered entries plus the one in flight must leave room for a new beat.
    assign used         = {1'b0, occ_q} + (CW + 1)'(infl_q);
    assign addr_ready_o = up_q && (used < (CW + 1)'(BUF_DEPTH));
    assign hs           = addr_valid_i && addr_ready_o;
    assign sram_cs_o    = hs && !oor;
    assign sram_addr_o  = addr_i[HI-1:OFT];

    assign push = infl_q;
    assign pop  = rvalid_o && rready_i;

    // Entry built from the captured beat and the SRAM data arriving this cycle.
    always_comb begin
        push_entry.id   = infl_id_q;
        push_entry.data = infl_err_q ? '0 : sram_rdata_i;
        push_entry.resp = infl_err_q ? 2'b10 : 2'b00;
        push_entry.last = infl_last_q;
    end

    // Head of the buffer drives the R channel directly from storage.
    assign head     = mem_q[rd_ptr_q];
    assign rid_o    = head.id;
    assign rdata_o  = head.data;
    assign rresp_o  = head.resp;
    assign rlast_o  = head.last;
    assign rvalid_o = (occ_q != '0);

    // In-flight capture, buffer storage, pointers and occupancy.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            up_q        <= 1'b0;
            infl_q      <= 1'b0;
            infl_id_q   <= '0;
            infl_last_q <= 1'b0;
            infl_err_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            up_q   <= 1'b1;
            infl_q <= hs;
            if (hs) begin
                infl_id_q   <= id_i;
                infl_last_q <= addr_last_i;
                infl_err_q  <= oor;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + CW'(1);
            end else if (!push && pop) begin
                occ_q <= occ_q - CW'(1);
            end
        end
    end

    // The credit rule must never let a push land on a full buffer.
    a_no_overflow: assert property (@(posedge aclk_i) disable iff (areset_i)
        !(push && !pop && occ_q == CW'(BUF_DEPTH)));

endmodule
